// File: rtl/dm_access_ctrl.sv
// Memory-stage access controller: word/sub-word loads, read-modify-write sub-word stores, misalignment checks.
// Latency: loads and SW are zero-latency; SH/SB take 2 cycles with stall high for the first cycle only.
module dm_access_ctrl #(
    parameter bit SUPPRESS_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_PC,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        addr_err,
    output logic        dm_MemWrite,
    output logic [31:0] dm_PC,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_writeData,
    input  logic [31:0] dm_readData
);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t      state;
    logic [31:0] merge_reg;
    logic [31:0] addr_reg;
    logic [31:0] pc_reg;

    logic        misaligned;
    logic        start_rmw;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] merged;

    always_comb begin
        misaligned = 1'b0;
        case (req_op)
            OP_LW, OP_SW:         misaligned = (req_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: misaligned = req_addr[0];
            default:              misaligned = 1'b0;
        endcase
    end

    assign sel_byte = dm_readData[{req_addr[1:0], 3'b000} +: 8];
    assign sel_half = req_addr[1] ? dm_readData[31:16] : dm_readData[15:0];

    // An unsuppressed misaligned SH is merged into the half selected by addr[1].
    assign start_rmw = (state == IDLE) && req_valid &&
                       ((req_op == OP_SB) ||
                        ((req_op == OP_SH) && (!misaligned || !SUPPRESS_MISALIGNED)));

    always_comb begin
        merged = dm_readData;
        if (req_op == OP_SB) begin
            merged[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
        end else if (req_addr[1]) begin
            merged[31:16] = req_wdata[15:0];
        end else begin
            merged[15:0] = req_wdata[15:0];
        end
    end

    always_comb begin
        stall        = 1'b0;
        load_data    = 32'h0;
        addr_err     = 1'b0;
        dm_MemWrite  = 1'b0;
        dm_addr      = req_addr;
        dm_PC        = req_PC;
        dm_writeData = 32'h0;
        if (state == RMW_WR) begin
            dm_MemWrite  = 1'b1;
            dm_addr      = addr_reg;
            dm_writeData = merge_reg;
            dm_PC        = pc_reg;
        end else if (req_valid) begin
            addr_err = misaligned;
            case (req_op)
                OP_LW:  load_data = dm_readData;
                OP_LH:  load_data = {{16{sel_half[15]}}, sel_half};
                OP_LHU: load_data = {16'h0, sel_half};
                OP_LB:  load_data = {{24{sel_byte[7]}}, sel_byte};
                OP_LBU: load_data = {24'h0, sel_byte};
                OP_SW: begin
                    if (!misaligned || !SUPPRESS_MISALIGNED) begin
                        dm_MemWrite  = 1'b1;
                        dm_addr      = {req_addr[31:2], 2'b00};
                        dm_writeData = req_wdata;
                    end
                end
                default: stall = start_rmw;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            merge_reg <= 32'h0;
            addr_reg  <= 32'h0;
            pc_reg    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_rmw) begin
                        merge_reg <= merged;
                        addr_reg  <= {req_addr[31:2], 2'b00};
                        pc_reg    <= req_PC;
                        state     <= RMW_WR;
                    end
                end
                RMW_WR:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboarded bench for dm_access_ctrl: a word memory stands in for dm, a separate golden memory feeds the expectations.
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] req_PC = 32'h0;
    logic        stall, addr_err, dm_MemWrite;
    logic [31:0] load_data, dm_PC, dm_addr, dm_writeData, dm_readData;

    always #5 clk = ~clk;

    dm_access_ctrl #(.SUPPRESS_MISALIGNED(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_PC(req_PC),
        .stall(stall), .load_data(load_data), .addr_err(addr_err),
        .dm_MemWrite(dm_MemWrite), .dm_PC(dm_PC), .dm_addr(dm_addr),
        .dm_writeData(dm_writeData), .dm_readData(dm_readData)
    );

    // Stand-in data memory: async read, sync write, reset clears and wins over writes.
    logic [31:0] mem [1024];
    assign dm_readData = mem[dm_addr[11:2]];
    always @(posedge clk) begin
        if (reset) begin
            foreach (mem[i]) mem[i] <= 32'h0;
        end else if (dm_MemWrite) begin
            mem[dm_addr[11:2]] <= dm_writeData;
        end
    end

    logic [31:0] ref_mem [1024];

    typedef struct {
        logic        stall;
        logic        err;
        logic        we;
        logic [31:0] ld;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t idle_exp();
        exp_t e;
        e.stall = 1'b0; e.err = 1'b0; e.we = 1'b0;
        e.ld = 32'h0; e.addr = 32'h0; e.wd = 32'h0; e.pc = 32'h0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per driven cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall", {31'h0, stall}, {31'h0, e.stall});
                chk("addr_err", {31'h0, addr_err}, {31'h0, e.err});
                chk("MemWrite", {31'h0, dm_MemWrite}, {31'h0, e.we});
                chk("load_data", load_data, e.ld);
                chk("writeData", dm_writeData, e.wd);
                if (e.we) begin
                    chk("dm_addr", dm_addr, e.addr);
                    chk("dm_PC", dm_PC, e.pc);
                end
            end
        end
    end

    function automatic logic mis_ref(input logic [2:0] op, input logic [31:0] a);
        if (op == 3'd0 || op == 3'd5) return (a % 4) != 0;
        if (op == 3'd1 || op == 3'd2 || op == 3'd6) return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] load_ref(input logic [2:0] op, input logic [31:0] w, input logic [31:0] a);
        logic [31:0] b, h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (op)
            3'd0: return w;
            3'd1: return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            3'd2: return h;
            3'd3: return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
            3'd4: return b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] merge_ref(input logic [2:0] op, input logic [31:0] w,
                                              input logic [31:0] a, input logic [31:0] d);
        int sh;
        logic [31:0] mask;
        if (op == 3'd7) begin
            sh = 8 * (a % 4); mask = 32'hFF;
        end else begin
            sh = 16 * ((a / 2) % 2); mask = 32'hFFFF;
        end
        return (w & ~(mask << sh)) | ((d & mask) << sh);
    endfunction

    task automatic cyc(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] pc, input logic rst, input exp_t e);
        @(posedge clk);
        #1;
        reset = rst; req_valid = v; req_op = op; req_addr = a; req_wdata = wd; req_PC = pc;
        q.push_back(e);
    endtask

    task automatic idle_cycle(input logic rst);
        cyc(1'b0, 3'd0, $urandom, $urandom, $urandom, rst, idle_exp());
        if (rst) foreach (ref_mem[i]) ref_mem[i] = 32'h0;
    endtask

    task automatic access(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        exp_t        e1, e2;
        int          w;
        logic        mis;
        logic [31:0] pc;
        w = (a / 4) % 1024;
        mis = mis_ref(op, a);
        pc = $urandom;
        e1 = idle_exp();
        e1.err = mis;
        if (op <= 3'd4) begin
            e1.ld = load_ref(op, ref_mem[w], a);
            cyc(1'b1, op, a, d, pc, 1'b0, e1);
        end else if (op == 3'd5 || mis) begin
            if (!mis) begin
                e1.we = 1'b1; e1.addr = a; e1.wd = d; e1.pc = pc;
                ref_mem[w] = d;
            end
            cyc(1'b1, op, a, d, pc, 1'b0, e1);
        end else begin
            e1.stall = 1'b1;
            cyc(1'b1, op, a, d, pc, 1'b0, e1);
            e2 = idle_exp();
            e2.we = 1'b1; e2.addr = a & 32'hFFFFFFFC; e2.pc = pc;
            e2.wd = merge_ref(op, ref_mem[w], a, d);
            ref_mem[w] = e2.wd;
            cyc(1'b1, op, a, d, pc, 1'b0, e2);
        end
    endtask

    initial begin
        exp_t e;
        logic [31:0] pc;
        int   guard;
        foreach (ref_mem[i]) ref_mem[i] = 32'h0;

        idle_cycle(1'b1);
        idle_cycle(1'b1);
        idle_cycle(1'b0);

        access(3'd5, 32'h10, 32'h8899AABB);
        access(3'd3, 32'h11, 32'h0);
        access(3'd4, 32'h11, 32'h0);
        access(3'd1, 32'h12, 32'h0);
        access(3'd2, 32'h12, 32'h0);
        access(3'd5, 32'h20, 32'h12345678);
        access(3'd0, 32'h20, 32'h0);
        access(3'd7, 32'h22, 32'h000000EE);
        access(3'd0, 32'h20, 32'h0);
        access(3'd6, 32'h20, 32'h0000BEEF);
        access(3'd6, 32'h22, 32'h0000CAFE);
        access(3'd0, 32'h20, 32'h0);
        access(3'd5, 32'h21, 32'hDEADDEAD);
        access(3'd1, 32'h23, 32'h0);
        access(3'd6, 32'h25, 32'h00001111);
        access(3'd0, 32'h20, 32'h0);
        access(3'd0, 32'h24, 32'h0);

        // Reset lands while the SB merge is pending: the write must not reach memory.
        access(3'd5, 32'h30, 32'hA5A5A5A5);
        pc = 32'h400;
        e = idle_exp();
        e.stall = 1'b1;
        cyc(1'b1, 3'd7, 32'h31, 32'h77, pc, 1'b0, e);
        e = idle_exp();
        e.we = 1'b1; e.addr = 32'h30; e.pc = pc;
        e.wd = merge_ref(3'd7, ref_mem[12], 32'h31, 32'h77);
        cyc(1'b1, 3'd7, 32'h31, 32'h77, pc, 1'b1, e);
        foreach (ref_mem[i]) ref_mem[i] = 32'h0;
        idle_cycle(1'b0);
        access(3'd0, 32'h30, 32'h0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) idle_cycle(1'b0);
            else access(3'($urandom_range(0, 7)), 32'($urandom_range(0, 63)), $urandom);
        end

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
